unidad_control: RTL
===================

// Module: unidad_control
// PURPOSE
//  Control-unit counterpart of the register/ALU datapath; the datapath consumes Ra..Wac,Wt,S,R.
//  Accepts one 8-bit register-transfer instruction per start/ready handshake.
//  Sequences the read/write strobes that move operands over bus1 into T, through the ALU
//  into AC, and back to a destination register. Pulses done when the instruction retires.
// PARAMETERS
//  IW  8  instruction width; fixed layout below, other values unsupported
// PORTS
//  clk      in   1   system clock; all state updates on posedge
//  reset    in   1   asynchronous, active-high reset
//  start    in   1   instruction valid; accepted when start & ready
//  instr    in   IW  {op[7:6], src1[5:4], src2[3:2], dst[1:0]}
//  ready    out  1   unit idle, can accept an instruction
//  done     out  1   one-cycle pulse: instruction retired
//  Ra,Rb,Rc out  1   drive A/B/C onto bus1
//  Rac      out  1   drive AC onto bus1
//  Wa,Wb,Wc out  1   load A/B/C from bus1
//  Wac      out  1   load AC from ALU output (bus3)
//  Wt       out  1   load T from bus1
//  S,R      out  1   ALU select: 10 = add (T+bus1), 01 = sub (T-bus1), 00 = zero
// BEHAVIOUR
//  Reg codes: 00=A 01=B 10=C 11=AC. Ops: 00 MOV, 01 ADD, 10 SUB, 11 NOP.
//  States: IDLE, LDT, ALU, WB, MV, DONE.
//  All strobes are decoded from the state register and IR only; no comb path from start/instr.
//  Reset (async, any state): state=IDLE, IR=0, ready=1, done=0, all strobes=0.
//  IDLE:  ready=1. On start, latch instr into IR. Then ADD/SUB->LDT, MOV->MV, NOP->DONE.
//  LDT:   R<src1>=1, Wt=1.                              Next: ALU.
//  ALU:   R<src2>=1, Wac=1. ADD: S=1,R=0. SUB: S=0,R=1. Next: WB.
//  WB:    If dst!=AC: Rac=1, W<dst>=1. If dst==AC: no strobes (result already in AC). Next: DONE.
//  MV:    If src1!=dst: R<src1>=1, W<dst>=1; else no strobes. dst==AC uses Wac with S=R=0? NO:
//         MOV into AC is illegal; treat it as NOP (no strobes).                   Next: DONE.
//  DONE:  done=1 for exactly one cycle; ready=0.                                 Next: IDLE.
//  Latency, accept edge to done high: ADD/SUB 4 cycles, MOV 2, NOP 1. Back-to-back issue:
//  the next accept occurs in the cycle after DONE.
//  Invariants, every cycle:
//   - at most one of Ra,Rb,Rc,Rac is high (single bus1 driver)
//   - S&R is never 1
//   - ready=0 in every non-IDLE state
//  start while ready=0 is ignored; IR is not altered.
//  src1==src2 is legal (e.g. A+A). src=AC in LDT/ALU reads the current AC; Wac in ALU takes
//  effect at the end of that cycle.
//  Reset mid-operation aborts: no pending write is issued after reset deasserts.
// CONFIGURATION
//  UC_INSTR_COUNT_EN defined: adds port instr_count out 16 = retired-instruction count.
//   Counts +1 on each done pulse, including NOP. Wraps FFFF->0000. Reset to 0.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Shared package uc_pkg holds the state encoding, the opcode localparams (OP_MOV/ADD/SUB/NOP),
//  the register-code localparams (REG_A/B/C/AC), and the instr field offsets.
//  Sub-module uc_reg_decoder: (code[1:0], en) -> {A,B,C,AC} one-hot.
//   One instance for read strobes, one for write strobes.
// TESTING
//  1 Reset asserted mid-stream -> all strobes=0, done=0, ready=1 asynchronously; IDLE after release.
//  2 A=10,B=10; instr=8'h46 (ADD A,B->C) -> cycle sequence {Ra,Wt},{Rb,Wac,S},{Rac,Wc},done;
//    C=20 in the attached datapath.
//  3 A=10,C=20; instr=8'hA1 (SUB C,A->B) -> {Rc,Wt},{Ra,Wac,R},{Rac,Wb},done; B=10.
//  4 instr=8'h10 (MOV B->A) -> {Rb,Wa} one cycle, done next cycle; A==B afterwards.
//    instr=8'hC0 (NOP) -> done one cycle after accept, no strobes.
//  5 start held high during ADD with a different instr -> ignored; next accept after DONE.
//    Reset asserted in ALU state -> no Wc is ever issued.
//  6 Random legal instructions for 1000 cycles -> bus-exclusivity and S&R assertions never fire.
//    With UC_INSTR_COUNT_EN, instr_count equals the number of done pulses.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared definitions for the register-transfer control unit: FSM state
// encoding, opcode and register codes, and instruction field offsets.
package uc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LDT,
    ST_ALU,
    ST_WB,
    ST_MV,
    ST_DONE
  } state_t;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [1:0] REG_A  = 2'b00;
  localparam logic [1:0] REG_B  = 2'b01;
  localparam logic [1:0] REG_C  = 2'b10;
  localparam logic [1:0] REG_AC = 2'b11;

  // Instruction layout: {op, src1, src2, dst}, two bits each.
  localparam int OP_LSB   = 6;
  localparam int SRC1_LSB = 4;
  localparam int SRC2_LSB = 2;
  localparam int DST_LSB  = 0;

endpackage

// File: rtl/uc_if.sv
// Instruction handshake and datapath strobe bundle between an instruction
// issuer (master) and the control unit (slave).
interface uc_if #(
  parameter int IW = 8
) ();

  logic          start;
  logic [IW-1:0] instr;
  logic          ready;
  logic          done;
  logic          Ra, Rb, Rc, Rac;
  logic          Wa, Wb, Wc, Wac;
  logic          Wt;
  logic          S, R;

  modport master (
    output start, instr,
    input  ready, done, Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wac, Wt, S, R
  );

  modport slave (
    input  start, instr,
    output ready, done, Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wac, Wt, S, R
  );

endinterface

// File: rtl/uc_reg_decoder.sv
// Turns a 2-bit register code plus enable into one-hot A/B/C/AC selects.
module uc_reg_decoder
  import uc_pkg::*;
(
  input  logic [1:0] code,
  input  logic       en,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       ac
);

  // One-hot decode; all selects low when disabled.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    a  = 1'b0;
    b  = 1'b0;
    c  = 1'b0;
    ac = 1'b0;
    if (en) begin
      unique case (code)
        REG_A:   a  = 1'b1;
        REG_B:   b  = 1'b1;
        REG_C:   c  = 1'b1;
        REG_AC:  ac = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/unidad_control.sv
// Control unit for the A/B/C/AC/T register + ALU datapath. Accepts one
// instruction per start/ready handshake and sequences bus1 read strobes,
// register write strobes and the ALU select, then pulses done.
// Optional feature: define UC_INSTR_COUNT_EN to add the 16-bit
// instr_count port counting retired instructions.
module unidad_control
  import uc_pkg::*;
#(
  parameter int IW = 8
) (
  input  logic        clk,
  input  logic        reset,
  uc_if.slave         bus
`ifdef UC_INSTR_COUNT_EN
  ,
  output logic [15:0] instr_count
`endif
);

  state_t        state;
  logic [IW-1:0] ir;
  logic          ready_q;
  logic          done_q;

  logic [1:0] ir_op, ir_src1, ir_src2, ir_dst;
  logic [1:0] in_op;

  assign ir_op   = ir[OP_LSB   +: 2];
  assign ir_src1 = ir[SRC1_LSB +: 2];
  assign ir_src2 = ir[SRC2_LSB +: 2];
  assign ir_dst  = ir[DST_LSB  +: 2];
  assign in_op   = bus.instr[OP_LSB +: 2];

  // Sequencer: state, instruction register and the registered ready/done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      ir      <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; later assignments in a branch override these defaults.
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (bus.start) begin
            ir      <= bus.instr;
            ready_q <= 1'b0;
            unique case (in_op)
              OP_ADD, OP_SUB: state <= ST_LDT;
              OP_MOV:         state <= ST_MV;
              default: begin
                state  <= ST_DONE;
                done_q <= 1'b1;
              end
            endcase
          end
        end
        ST_LDT: state <= ST_ALU;
        ST_ALU: state <= ST_WB;
        ST_WB: begin
          state  <= ST_DONE;
          done_q <= 1'b1;
        end
        ST_MV: begin
          state  <= ST_DONE;
          done_q <= 1'b1;
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  logic [1:0] rd_code, wr_code;
  logic       rd_en, wr_en;
  logic       wt, sel_s, sel_r;
  logic       mv_ok;

  // MOV with identical source/destination, or into AC, issues no strobes.
  assign mv_ok = (ir_src1 != ir_dst) && (ir_dst != REG_AC);

  // Strobe selection decoded only from the state register and IR.
  always_comb begin
    rd_code = ir_src1;
    rd_en   = 1'b0;
    wr_code = ir_dst;
    wr_en   = 1'b0;
    wt      = 1'b0;
    sel_s   = 1'b0;
    sel_r   = 1'b0;
    unique case (state)
      ST_LDT: begin
        rd_code = ir_src1;
        rd_en   = 1'b1;
        wt      = 1'b1;
      end
      ST_ALU: begin
        rd_code = ir_src2;
        rd_en   = 1'b1;
        wr_code = REG_AC;
        wr_en   = 1'b1;
        sel_s   = (ir_op == OP_ADD);
        sel_r   = (ir_op == OP_SUB);
      end
      ST_WB: begin
        rd_code = REG_AC;
        rd_en   = (ir_dst != REG_AC);
        wr_code = ir_dst;
        wr_en   = (ir_dst != REG_AC);
      end
      ST_MV: begin
        rd_code = ir_src1;
        rd_en   = mv_ok;
        wr_code = ir_dst;
        wr_en   = mv_ok;
      end
      default: ;
    endcase
  end

  uc_reg_decoder u_rd_dec (
    .code (rd_code),
    .en   (rd_en),
    .a    (bus.Ra),
    .b    (bus.Rb),
    .c    (bus.Rc),
    .ac   (bus.Rac)
  );

  uc_reg_decoder u_wr_dec (
    .code (wr_code),
    .en   (wr_en),
    .a    (bus.Wa),
    .b    (bus.Wb),
    .c    (bus.Wc),
    .ac   (bus.Wac)
  );

  assign bus.Wt    = wt;
  assign bus.S     = sel_s;
  assign bus.R     = sel_r;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;

`ifdef UC_INSTR_COUNT_EN
  // Retired-instruction counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= 16'd0;
    end else if (done_q) begin
      instr_count <= instr_count + 16'd1;
    end
  end
`endif

endmodule
